// File: rtl/codec_init_pkg.sv
// Shared types and constants for the codec power-up sequencer.
package codec_init_pkg;

  localparam int REG_ADDR_W = 16;
  localparam int REG_DATA_W = 8;
  localparam int ENTRY_W    = REG_ADDR_W + REG_DATA_W;

  localparam logic [REG_ADDR_W-1:0] TERMINATOR = 16'hFFFF;

  typedef enum logic [3:0] {
    IDLE,
    SETTLE,
    FETCH,
    LATCH,
    DEV,
    RAH,
    RAL,
    DAT,
    NEXT,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/codec_init_seq.sv
// Walks the codec register table and issues each entry as a 4-byte I2C write.
// Optional NACK retry is built when CODEC_INIT_RETRY_EN is defined.
module codec_init_seq
  import codec_init_pkg::*;
#(
  parameter logic [6:0] CODEC_ADDR    = 7'h3B,
  parameter int         NUM_ENTRIES   = 32,
  parameter int         SETTLE_CYCLES = 1000,
  parameter int         MAX_RETRY     = 3
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [7:0]         err_index,
  output logic [7:0]         tbl_addr,
  input  logic [ENTRY_W-1:0] tbl_data,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [7:0]         cmd_data,
  output logic               cmd_start,
  output logic               cmd_stop,
  input  logic               rsp_valid,
  input  logic               rsp_nack,
  output logic               i2s_enable
);

  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);

  state_t                  state;
  logic [31:0]             settle_cnt;
  logic [8:0]              index;
  logic [8:0]              index_inc;
  logic                    last_entry;
  logic                    wait_rsp;
  logic                    in_byte_state;
  logic                    rsp_take;
  logic [REG_ADDR_W-1:0]   reg_addr;
  logic [REG_DATA_W-1:0]   reg_data;
  logic [7:0]              byte_data;
  state_t                  byte_next;

`ifdef CODEC_INIT_RETRY_EN
  logic [7:0]              retry_cnt;
`else
  logic                    unused_max_retry;
  assign unused_max_retry = ^MAX_RETRY;
`endif

  assign index_inc     = index + 9'd1;
  assign last_entry    = (index_inc == 9'(NUM_ENTRIES));
  assign in_byte_state = state inside {DEV, RAH, RAL, DAT};
  // A response may arrive in the same cycle as the handshake that carried its byte.
  assign rsp_take      = in_byte_state && rsp_valid && (wait_rsp || (cmd_valid && cmd_ready));
  assign i2s_enable    = done;

  always_comb begin
    byte_data = {CODEC_ADDR, 1'b0};
    byte_next = NEXT;
    case (state)
      DEV: begin byte_data = {CODEC_ADDR, 1'b0}; byte_next = RAH; end
      RAH: begin byte_data = reg_addr[15:8];     byte_next = RAL; end
      RAL: begin byte_data = reg_addr[7:0];      byte_next = DAT; end
      DAT: begin byte_data = reg_data;           byte_next = NEXT; end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state      <= IDLE;
      settle_cnt <= '0;
      index      <= '0;
      wait_rsp   <= 1'b0;
      reg_addr   <= '0;
      reg_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_index  <= '0;
      tbl_addr   <= '0;
      cmd_valid  <= 1'b0;
      cmd_data   <= '0;
      cmd_start  <= 1'b0;
      cmd_stop   <= 1'b0;
`ifdef CODEC_INIT_RETRY_EN
      retry_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            err_index  <= '0;
            index      <= '0;
            tbl_addr   <= '0;
            settle_cnt <= '0;
`ifdef CODEC_INIT_RETRY_EN
            retry_cnt  <= '0;
`endif
            state      <= (SETTLE_CYCLES == 0) ? FETCH : SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) state <= FETCH;
          else                           settle_cnt <= settle_cnt + 32'd1;
        end
        FETCH: state <= LATCH;
        LATCH: begin
          reg_addr <= tbl_data[ENTRY_W-1:REG_DATA_W];
          reg_data <= tbl_data[REG_DATA_W-1:0];
          if (tbl_data[ENTRY_W-1:REG_DATA_W] == TERMINATOR) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= DEV;
          end
        end
        DEV, RAH, RAL, DAT: begin
          if (!cmd_valid && !wait_rsp) begin
            cmd_valid <= 1'b1;
            cmd_data  <= byte_data;
            cmd_start <= (state == DEV);
            cmd_stop  <= (state == DAT);
          end else if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
            wait_rsp  <= 1'b1;
          end
          if (rsp_take) begin
            wait_rsp <= 1'b0;
            if (rsp_nack) begin
`ifdef CODEC_INIT_RETRY_EN
              if (32'(retry_cnt) < MAX_RETRY) begin
                retry_cnt <= retry_cnt + 8'd1;
                state     <= DEV;
              end else begin
                state     <= ERR;
                error     <= 1'b1;
                err_index <= index[7:0];
                busy      <= 1'b0;
              end
`else
              state     <= ERR;
              error     <= 1'b1;
              err_index <= index[7:0];
              busy      <= 1'b0;
`endif
            end else if (state == DAT && last_entry) begin
              // Finish straight from the last response so done follows it by one cycle.
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= byte_next;
            end
          end
        end
        NEXT: begin
          index    <= index_inc;
          tbl_addr <= index_inc[7:0];
`ifdef CODEC_INIT_RETRY_EN
          retry_cnt <= '0;
`endif
          if (last_entry) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_codec_init_seq.sv
// Directed bench for codec_init_seq with a table model and a byte-level I2C engine model.
module tb_codec_init_seq;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        start;
  logic        busy, done, error, i2s_enable;
  logic [7:0]  err_index, tbl_addr;
  logic [23:0] tbl_data;
  logic        cmd_valid, cmd_ready, cmd_start, cmd_stop;
  logic [7:0]  cmd_data;
  logic        rsp_valid, rsp_nack;

  logic [23:0] tbl_mem [0:255];
  logic [9:0]  log_q[$];
  logic [9:0]  exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // engine controls
  logic ready_block = 1'b0;
  logic coincident  = 1'b0;
  int   nack_left   = 0;
  int   nack_idx    = 0;
  int   nack_pos    = 0;

  codec_init_seq #(
    .CODEC_ADDR(7'h3B), .NUM_ENTRIES(6), .SETTLE_CYCLES(3), .MAX_RETRY(3)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .busy(busy), .done(done),
    .error(error), .err_index(err_index), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .rsp_valid(rsp_valid),
    .rsp_nack(rsp_nack), .i2s_enable(i2s_enable)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) tbl_data <= tbl_mem[tbl_addr];

  // Engine model: records each accepted byte and answers one cycle later (or at once).
  initial begin
    logic hs_pending;
    logic pend_nack;
    logic nk;
    int   pos;
    hs_pending = 1'b0;
    pend_nack  = 1'b0;
    pos        = 0;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_nack   = 1'b0;
    forever begin
      @(negedge ACLK);
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      if (!ARESETN) begin
        hs_pending = 1'b0;
        cmd_ready  = 1'b0;
      end else begin
        if (hs_pending) begin
          rsp_valid  = 1'b1;
          rsp_nack   = pend_nack;
          hs_pending = 1'b0;
        end
        cmd_ready = !ready_block;
        if (cmd_valid && cmd_ready) begin
          pos = cmd_start ? 0 : pos + 1;
          log_q.push_back({cmd_start, cmd_stop, cmd_data});
          nk = (nack_left > 0) && (int'(tbl_addr) == nack_idx) && (pos == nack_pos);
          if (nk) nack_left--;
          if (coincident) begin
            rsp_valid = 1'b1;
            rsp_nack  = nk;
          end else begin
            hs_pending = 1'b1;
            pend_nack  = nk;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    @(negedge ACLK);
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
  endtask

  function automatic logic [9:0] expByte(input int e, input int p);
    logic [23:0] ent;
    ent = tbl_mem[e];
    case (p)
      0:       return {1'b1, 1'b0, 8'h76};
      1:       return {1'b0, 1'b0, ent[23:16]};
      2:       return {1'b0, 1'b0, ent[15:8]};
      default: return {1'b0, 1'b1, ent[7:0]};
    endcase
  endfunction

  task automatic pushEntry(input int e, input int nbytes);
    for (int p = 0; p < nbytes; p++) exp_q.push_back(expByte(e, p));
  endtask

  task automatic clearLogs();
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic checkStream(input string tag);
    int n;
    checkOutput({tag, "_count"}, 64'(log_q.size()), 64'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int k = 0; k < n; k++)
      checkOutput($sformatf("%s_byte%0d", tag, k), 64'(log_q[k]), 64'(exp_q[k]));
  endtask

  task automatic waitIdle(input string tag);
    int cyc;
    cyc = 0;
    while (busy && cyc < 3000) begin
      @(negedge ACLK);
      cyc++;
    end
    checkOutput({tag, "_timeout"}, 64'(busy), 64'(0));
  endtask

  function automatic logic [30:0] allOutputs();
    return {busy, done, error, err_index, tbl_addr, cmd_valid, cmd_data,
            cmd_start, cmd_stop, i2s_enable};
  endfunction

  initial begin
    logic seen;
    logic found;
    ARESETN = 1'b0;
    start   = 1'b0;
    for (int i = 0; i < 256; i++) tbl_mem[i] = 24'h0;
    tbl_mem[0] = 24'h400001;
    tbl_mem[1] = 24'h401501;
    tbl_mem[2] = 24'hFFFF00;
    tbl_mem[3] = 24'h40F9C3;
    tbl_mem[4] = 24'h410200;
    tbl_mem[5] = 24'h4210A5;
    tbl_mem[6] = 24'h123456;

    repeat (3) @(negedge ACLK);
    checkOutput("reset_outputs", 64'(allOutputs()), 64'(0));
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);

    // Two entries then a terminator; also check start-to-first-byte latency.
    $display("[TB] two-entry write with terminator at entry 2");
    clearLogs();
    applyStimulus();
    checkOutput("busy_after_start", 64'(busy), 64'(1));
    repeat (5) @(negedge ACLK);
    checkOutput("cmd_valid_not_yet", 64'(cmd_valid), 64'(0));
    @(negedge ACLK);
    checkOutput("first_byte", 64'({cmd_valid, cmd_start, cmd_stop, cmd_data}),
                64'({1'b1, 1'b1, 1'b0, 8'h76}));
    waitIdle("twoentry");
    pushEntry(0, 4);
    pushEntry(1, 4);
    checkStream("twoentry");
    checkOutput("twoentry_status", 64'({done, i2s_enable, error}), 64'(3'b110));

    // Terminator at entry 3 with a real entry in slot 2.
    $display("[TB] terminator at entry 3");
    tbl_mem[2] = 24'h401C1A;
    tbl_mem[3] = 24'hFFFF00;
    clearLogs();
    applyStimulus();
    checkOutput("done_cleared_by_start", 64'(done), 64'(0));
    waitIdle("term3");
    for (int e = 0; e < 3; e++) pushEntry(e, 4);
    checkStream("term3");
    checkOutput("term3_done", 64'({done, error}), 64'(2'b10));

    // Full table up to NUM_ENTRIES, responses coincident with the handshake.
    $display("[TB] full table, coincident responses");
    tbl_mem[3] = 24'h40F9C3;
    coincident = 1'b1;
    clearLogs();
    applyStimulus();
    waitIdle("full");
    for (int e = 0; e < 6; e++) pushEntry(e, 4);
    checkStream("full");
    checkOutput("full_status", 64'({done, i2s_enable, error, tbl_addr}),
                64'({3'b110, 8'd5}));
    coincident = 1'b0;

    // NACK on the RAL byte of entry 5.
    $display("[TB] NACK on RAL of entry 5");
    nack_idx = 5;
    nack_pos = 2;
`ifdef CODEC_INIT_RETRY_EN
    nack_left = 4;
`else
    nack_left = 1;
`endif
    clearLogs();
    applyStimulus();
    waitIdle("nack5");
    for (int e = 0; e < 5; e++) pushEntry(e, 4);
`ifdef CODEC_INIT_RETRY_EN
    for (int r = 0; r < 4; r++) pushEntry(5, 3);
`else
    pushEntry(5, 3);
`endif
    checkStream("nack5");
    checkOutput("nack5_status", 64'({error, done, busy, i2s_enable, err_index}),
                64'({4'b1000, 8'd5}));
    seen = 1'b0;
    repeat (20) begin
      @(negedge ACLK);
      seen = seen | cmd_valid;
    end
    checkOutput("nack5_quiet", 64'(seen), 64'(0));

    // Two NACKs on the DAT byte of entry 2.
    $display("[TB] two NACKs on entry 2");
    nack_idx  = 2;
    nack_pos  = 3;
    nack_left = 2;
    clearLogs();
    applyStimulus();
    checkOutput("error_cleared_by_start", 64'({error, err_index}), 64'(0));
    waitIdle("retry2");
    pushEntry(0, 4);
    pushEntry(1, 4);
`ifdef CODEC_INIT_RETRY_EN
    for (int r = 0; r < 3; r++) pushEntry(2, 4);
    for (int e = 3; e < 6; e++) pushEntry(e, 4);
    checkStream("retry2");
    checkOutput("retry2_status", 64'({done, error}), 64'(2'b10));
`else
    pushEntry(2, 4);
    checkStream("retry2");
    checkOutput("retry2_status", 64'({done, error, err_index}), 64'({2'b01, 8'd2}));
`endif
    nack_left = 0;

    // Back-pressure: payload must hold while cmd_ready is low; mid-sequence start ignored.
    $display("[TB] stalled cmd_ready with stray start");
    ready_block = 1'b1;
    clearLogs();
    applyStimulus();
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge ACLK);
      found = cmd_valid;
    end
    checkOutput("stall_valid_seen", 64'(found), 64'(1));
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("stall_hold%0d", i), 64'({cmd_valid, cmd_data, cmd_start}),
                  64'({1'b1, 8'h76, 1'b1}));
      @(negedge ACLK);
      start = (i == 4);
    end
    start = 1'b0;
    checkOutput("stall_still_busy", 64'({busy, tbl_addr}), 64'({1'b1, 8'd0}));
    ready_block = 1'b0;
    waitIdle("stall");
    for (int e = 0; e < 6; e++) pushEntry(e, 4);
    checkStream("stall");
    checkOutput("stall_done", 64'(done), 64'(1));

    // Asynchronous reset during DAT of entry 1, then a clean rerun.
    $display("[TB] reset during DAT of entry 1");
    clearLogs();
    applyStimulus();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge ACLK);
      found = cmd_valid && cmd_stop && (tbl_addr == 8'd1);
    end
    checkOutput("reset_dat_reached", 64'(found), 64'(1));
    #2 ARESETN = 1'b0;
    #1 checkOutput("async_reset_outputs", 64'(allOutputs()), 64'(0));
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (3) @(negedge ACLK);
    checkOutput("post_reset_idle", 64'({busy, cmd_valid}), 64'(0));
    clearLogs();
    applyStimulus();
    repeat (5) @(negedge ACLK);
    checkOutput("rerun_not_yet", 64'(cmd_valid), 64'(0));
    @(negedge ACLK);
    checkOutput("rerun_first", 64'({cmd_valid, tbl_addr, cmd_data}),
                64'({1'b1, 8'd0, 8'h76}));
    waitIdle("rerun");
    for (int e = 0; e < 6; e++) pushEntry(e, 4);
    checkStream("rerun");
    checkOutput("rerun_done", 64'({done, error}), 64'(2'b10));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
